cache_refill_controller: RTL and testbench

- FSM between the core data port, the two-way LRU data cache and main memory.
- Reads: looks up the cache; on a miss, fetches the word from memory, fills the cache, then responds.
- Writes: write-through, updating the cache only on a hit.
- Keeps saturating hit/miss statistics counters. Way selection and replacement stay inside the cache.

---
 rtl/cache_refill_controller.sv | 126 ++++++++++++
 tb/tb_cache_refill_controller.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_controller.sv
// Refill controller between the core data port, the two-way LRU data cache and main memory.
// Loads fill the cache on a miss; stores are write-through with no write-allocate.
module cache_refill_controller #(
   parameter int ADDR_SIZE   = 32,
   parameter int BLOCK_SIZE  = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ADDR_SIZE-1:0]   req_addr,
   input  logic [BLOCK_SIZE-1:0]  req_wdata,
   output logic                   resp_valid,
   output logic [BLOCK_SIZE-1:0]  resp_rdata,
   output logic [ADDR_SIZE-1:0]   cache_addr,
   output logic                   cache_write_enable,
   output logic [BLOCK_SIZE-1:0]  cache_write_data,
   input  logic [BLOCK_SIZE-1:0]  cache_read_data,
   input  logic                   cache_hit,
   output logic                   mem_req_valid,
   input  logic                   mem_req_ready,
   output logic                   mem_write,
   output logic [ADDR_SIZE-1:0]   mem_addr,
   output logic [BLOCK_SIZE-1:0]  mem_wdata,
   input  logic                   mem_resp_valid,
   input  logic [BLOCK_SIZE-1:0]  mem_rdata,
   output logic [COUNT_WIDTH-1:0] hit_count,
   output logic [COUNT_WIDTH-1:0] miss_count
);

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MEM_REQ,
      MEM_WAIT,
      FILL,
      RESP
   } stateT;

   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

   stateT                  r_state;
   stateT                  w_nextState;
   logic [ADDR_SIZE-1:0]   r_addr;
   logic                   r_write;
   logic [BLOCK_SIZE-1:0]  r_wdata;
   logic [BLOCK_SIZE-1:0]  r_rdata;
   logic [COUNT_WIDTH-1:0] r_hitCount;
   logic [COUNT_WIDTH-1:0] r_missCount;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Request capture, load data staging and saturating statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr      <= '0;
         r_write     <= 1'b0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_hitCount  <= '0;
         r_missCount <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_addr  <= req_addr;
                  r_write <= req_write;
                  r_wdata <= req_wdata;
               end
            end
            LOOKUP: begin
               if (cache_hit) begin
                  if (r_hitCount != COUNT_MAX) r_hitCount <= r_hitCount + COUNT_ONE;
                  if (!r_write) r_rdata <= cache_read_data;
               end else begin
                  if (r_missCount != COUNT_MAX) r_missCount <= r_missCount + COUNT_ONE;
               end
            end
            MEM_WAIT: begin
               if (mem_resp_valid && !r_write) r_rdata <= mem_rdata;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:     if (req_valid) w_nextState = LOOKUP;
         LOOKUP:   w_nextState = (cache_hit && !r_write) ? RESP : MEM_REQ;
         MEM_REQ:  if (mem_req_ready) w_nextState = MEM_WAIT;
         MEM_WAIT: if (mem_resp_valid) w_nextState = r_write ? RESP : FILL;
         FILL:     w_nextState = RESP;
         RESP:     w_nextState = IDLE;
         default:  w_nextState = IDLE;
      endcase
   end

   // Cache writes happen on a store hit in LOOKUP and on the refill in FILL
   always_comb begin
      req_ready          = (r_state == IDLE);
      resp_valid         = (r_state == RESP);
      resp_rdata         = ((r_state == RESP) && !r_write) ? r_rdata : '0;
      cache_addr         = (r_state == IDLE) ? req_addr : r_addr;
      cache_write_enable = ((r_state == LOOKUP) && r_write && cache_hit) || (r_state == FILL);
      cache_write_data   = (r_state == FILL) ? r_rdata : r_wdata;
      mem_req_valid      = (r_state == MEM_REQ);
      mem_write          = r_write;
      mem_addr           = r_addr;
      mem_wdata          = r_wdata;
      hit_count          = r_hitCount;
      miss_count         = r_missCount;
   end

endmodule

// File: tb/tb_cache_refill_controller.sv
// Directed bench for cache_refill_controller with a small cache stand-in and a memory responder.
// A second instance built with COUNT_WIDTH=4 exercises counter saturation.
module tb_cache_refill_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [31:0] cache_addr;
   logic        cache_write_enable;
   logic [31:0] cache_write_data;
   logic [31:0] cache_read_data;
   logic        cache_hit;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   logic        s_req_valid;
   logic        s_req_ready;
   logic        s_req_write;
   logic [31:0] s_req_addr;
   logic [31:0] s_req_wdata;
   logic        s_resp_valid;
   logic [31:0] s_resp_rdata;
   logic [31:0] s_cache_addr;
   logic        s_cache_write_enable;
   logic [31:0] s_cache_write_data;
   logic [31:0] s_cache_read_data;
   logic        s_cache_hit;
   logic        s_mem_req_valid;
   logic        s_mem_req_ready;
   logic        s_mem_write;
   logic [31:0] s_mem_addr;
   logic [31:0] s_mem_wdata;
   logic        s_mem_resp_valid;
   logic [31:0] s_mem_rdata;
   logic [3:0]  s_hit_count;
   logic [3:0]  s_miss_count;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   cache_refill_controller dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .cache_addr(cache_addr), .cache_write_enable(cache_write_enable),
      .cache_write_data(cache_write_data), .cache_read_data(cache_read_data),
      .cache_hit(cache_hit),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   cache_refill_controller #(.COUNT_WIDTH(4)) satDut (
      .clk(clk), .rst(rst),
      .req_valid(s_req_valid), .req_ready(s_req_ready), .req_write(s_req_write),
      .req_addr(s_req_addr), .req_wdata(s_req_wdata),
      .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata),
      .cache_addr(s_cache_addr), .cache_write_enable(s_cache_write_enable),
      .cache_write_data(s_cache_write_data), .cache_read_data(s_cache_read_data),
      .cache_hit(s_cache_hit),
      .mem_req_valid(s_mem_req_valid), .mem_req_ready(s_mem_req_ready), .mem_write(s_mem_write),
      .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_resp_valid(s_mem_resp_valid), .mem_rdata(s_mem_rdata),
      .hit_count(s_hit_count), .miss_count(s_miss_count)
   );

   // The saturation instance always hits, so memory is never involved
   assign s_req_write       = 1'b0;
   assign s_req_addr        = 32'h0000_0200;
   assign s_req_wdata       = 32'h0;
   assign s_cache_hit       = 1'b1;
   assign s_cache_read_data = 32'h5555_AAAA;
   assign s_mem_req_ready   = 1'b1;
   assign s_mem_resp_valid  = 1'b0;
   assign s_mem_rdata       = 32'h0;

   // Cache stand-in: one entry per address[7:4], full-address tag
   bit          cValid [16];
   logic [31:0] cTag   [16];
   logic [31:0] cData  [16];

   assign cache_hit       = cValid[cache_addr[7:4]] && (cTag[cache_addr[7:4]] == cache_addr);
   assign cache_read_data = cData[cache_addr[7:4]];

   always @(posedge clk) begin
      if (cache_write_enable) begin
         cValid[cache_addr[7:4]] <= 1'b1;
         cTag[cache_addr[7:4]]   <= cache_addr;
         cData[cache_addr[7:4]]  <= cache_write_data;
      end
   end

   // Memory responder: ready after stallTarget cycles of request, ack the following cycle
   bit          memWritten [16];
   logic [31:0] memArr     [16];
   logic [31:0] memRdata;
   logic        memRespPending = 1'b0;
   logic [31:0] memLastWriteAddr = 32'h0;
   logic [31:0] memLastWriteData = 32'h0;
   int          stallCount = 0;
   int          stallTarget = 0;
   logic        holdResp = 1'b0;
   logic        forceResp = 1'b0;

   function automatic logic [31:0] defaultWord(input logic [31:0] a);
      case (a)
         32'h0000_0040: return 32'hDEAD_BEEF;
         32'h0000_00C0: return 32'h0BAD_F00D;
         default:       return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   assign mem_req_ready  = (stallCount >= stallTarget);
   assign mem_resp_valid = memRespPending | forceResp;
   assign mem_rdata      = memRdata;

   always @(posedge clk) begin
      stallCount <= mem_req_valid ? stallCount + 1 : 0;
      if (mem_req_valid && mem_req_ready) begin
         memRespPending <= !holdResp;
         memRdata <= memWritten[mem_addr[7:4]] ? memArr[mem_addr[7:4]] : defaultWord(mem_addr);
         if (mem_write) begin
            memArr[mem_addr[7:4]]     <= mem_wdata;
            memWritten[mem_addr[7:4]] <= 1'b1;
            memLastWriteAddr          <= mem_addr;
            memLastWriteData          <= mem_wdata;
         end
      end else if (mem_resp_valid) begin
         memRespPending <= 1'b0;
      end
   end

   // Free-running activity monitor; tasks work with differences of these counts
   int          memReqCycles = 0;
   int          cacheWriteCount = 0;
   int          respCount = 0;
   int          memUnstable = 0;
   logic        prevReqValid = 1'b0;
   logic [31:0] prevAddr;
   logic [31:0] prevWdata;
   logic        prevWrite;
   logic [31:0] lastCacheWriteAddr = 32'h0;
   logic [31:0] lastCacheWriteData = 32'h0;

   always @(negedge clk) begin
      if (mem_req_valid) memReqCycles <= memReqCycles + 1;
      if (mem_req_valid && prevReqValid &&
          ((mem_addr !== prevAddr) || (mem_wdata !== prevWdata) || (mem_write !== prevWrite)))
         memUnstable <= memUnstable + 1;
      prevReqValid <= mem_req_valid;
      prevAddr     <= mem_addr;
      prevWdata    <= mem_wdata;
      prevWrite    <= mem_write;
      if (cache_write_enable) begin
         cacheWriteCount    <= cacheWriteCount + 1;
         lastCacheWriteAddr <= cache_addr;
         lastCacheWriteData <= cache_write_data;
      end
      if (resp_valid) respCount <= respCount + 1;
   end

   // Issues one request and reports latency from the acceptance cycle, data and activity deltas
   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                                output int lat, output logic [31:0] rdata,
                                output int memReqD, output int cwD, output int respD);
      int mr0, cw0, rs0;
      @(posedge clk); #1;
      mr0 = memReqCycles; cw0 = cacheWriteCount; rs0 = respCount;
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
      @(posedge clk);
      lat = -1;
      rdata = 32'hxxxx_xxxx;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = 1'b0;
         if (resp_valid) begin
            lat = c;
            rdata = resp_rdata;
            break;
         end
      end
      @(posedge clk); #1;
      memReqD = memReqCycles - mr0;
      cwD     = cacheWriteCount - cw0;
      respD   = respCount - rs0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_req_ready got %0b want 1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_resp_valid got %0b want 0", resp_valid); end
      checks++; if (cache_write_enable !== 1'b0) begin fails++; $display("[TB] FAIL reset_cache_we got %0b want 0", cache_write_enable); end
      checks++; if (mem_req_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_req_valid got %0b want 0", mem_req_valid); end
      checks++; if (resp_rdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_resp_rdata got %h want 0", resp_rdata); end
      checks++; if (hit_count !== 16'h0) begin fails++; $display("[TB] FAIL reset_hit_count got %0d want 0", hit_count); end
      checks++; if (miss_count !== 16'h0) begin fails++; $display("[TB] FAIL reset_miss_count got %0d want 0", miss_count); end
      checks++; if (s_hit_count !== 4'h0) begin fails++; $display("[TB] FAIL reset_sat_hit_count got %0d want 0", s_hit_count); end
      rst = 1'b0;
   endtask

   task automatic test_read_miss;
      int lat, mr, cw, rs;
      logic [31:0] rd;
      applyStimulus(1'b0, 32'h0000_0040, 32'h0, lat, rd, mr, cw, rs);
      checks++; if (lat !== 5) begin fails++; $display("[TB] FAIL read_miss_latency got %0d want 5", lat); end
      checks++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL read_miss_rdata got %h want deadbeef", rd); end
      checks++; if (miss_count !== 16'd1) begin fails++; $display("[TB] FAIL read_miss_miss_count got %0d want 1", miss_count); end
      checks++; if (hit_count !== 16'd0) begin fails++; $display("[TB] FAIL read_miss_hit_count got %0d want 0", hit_count); end
      checks++; if (cw !== 1) begin fails++; $display("[TB] FAIL read_miss_fill_writes got %0d want 1", cw); end
      checks++; if (lastCacheWriteData !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL read_miss_fill_data got %h want deadbeef", lastCacheWriteData); end
      checks++; if (lastCacheWriteAddr !== 32'h0000_0040) begin fails++; $display("[TB] FAIL read_miss_fill_addr got %h want 00000040", lastCacheWriteAddr); end
      checks++; if (mr !== 1) begin fails++; $display("[TB] FAIL read_miss_mem_req_cycles got %0d want 1", mr); end
   endtask

   task automatic test_read_hit;
      int lat, mr, cw, rs;
      logic [31:0] rd;
      applyStimulus(1'b0, 32'h0000_0040, 32'h0, lat, rd, mr, cw, rs);
      checks++; if (lat !== 2) begin fails++; $display("[TB] FAIL read_hit_latency got %0d want 2", lat); end
      checks++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL read_hit_rdata got %h want deadbeef", rd); end
      checks++; if (hit_count !== 16'd1) begin fails++; $display("[TB] FAIL read_hit_hit_count got %0d want 1", hit_count); end
      checks++; if (mr !== 0) begin fails++; $display("[TB] FAIL read_hit_mem_req_cycles got %0d want 0", mr); end
      checks++; if (rs !== 1) begin fails++; $display("[TB] FAIL read_hit_resp_pulses got %0d want 1", rs); end
   endtask

   task automatic test_write_hit;
      int lat, mr, cw, rs;
      logic [31:0] rd;
      applyStimulus(1'b1, 32'h0000_0040, 32'h1234_5678, lat, rd, mr, cw, rs);
      checks++; if (lat !== 4) begin fails++; $display("[TB] FAIL write_hit_latency got %0d want 4", lat); end
      checks++; if (rd !== 32'h0) begin fails++; $display("[TB] FAIL write_hit_resp_rdata got %h want 0", rd); end
      checks++; if (cw !== 1) begin fails++; $display("[TB] FAIL write_hit_cache_writes got %0d want 1", cw); end
      checks++; if (lastCacheWriteData !== 32'h1234_5678) begin fails++; $display("[TB] FAIL write_hit_cache_data got %h want 12345678", lastCacheWriteData); end
      checks++; if (memLastWriteAddr !== 32'h0000_0040) begin fails++; $display("[TB] FAIL write_hit_mem_addr got %h want 00000040", memLastWriteAddr); end
      checks++; if (memLastWriteData !== 32'h1234_5678) begin fails++; $display("[TB] FAIL write_hit_mem_data got %h want 12345678", memLastWriteData); end
      checks++; if (hit_count !== 16'd2) begin fails++; $display("[TB] FAIL write_hit_hit_count got %0d want 2", hit_count); end
      applyStimulus(1'b0, 32'h0000_0040, 32'h0, lat, rd, mr, cw, rs);
      checks++; if (lat !== 2) begin fails++; $display("[TB] FAIL reread_latency got %0d want 2", lat); end
      checks++; if (rd !== 32'h1234_5678) begin fails++; $display("[TB] FAIL reread_rdata got %h want 12345678", rd); end
      checks++; if (hit_count !== 16'd3) begin fails++; $display("[TB] FAIL reread_hit_count got %0d want 3", hit_count); end
   endtask

   task automatic test_write_miss;
      int lat, mr, cw, rs;
      logic [31:0] rd;
      applyStimulus(1'b1, 32'h0000_0080, 32'hA5A5_A5A5, lat, rd, mr, cw, rs);
      checks++; if (lat !== 4) begin fails++; $display("[TB] FAIL write_miss_latency got %0d want 4", lat); end
      checks++; if (cw !== 0) begin fails++; $display("[TB] FAIL write_miss_cache_writes got %0d want 0", cw); end
      checks++; if (memLastWriteData !== 32'hA5A5_A5A5) begin fails++; $display("[TB] FAIL write_miss_mem_data got %h want a5a5a5a5", memLastWriteData); end
      checks++; if (miss_count !== 16'd2) begin fails++; $display("[TB] FAIL write_miss_miss_count got %0d want 2", miss_count); end
      applyStimulus(1'b0, 32'h0000_0080, 32'h0, lat, rd, mr, cw, rs);
      checks++; if (lat !== 5) begin fails++; $display("[TB] FAIL load_after_store_miss_latency got %0d want 5", lat); end
      checks++; if (rd !== 32'hA5A5_A5A5) begin fails++; $display("[TB] FAIL load_after_store_miss_rdata got %h want a5a5a5a5", rd); end
      checks++; if (miss_count !== 16'd3) begin fails++; $display("[TB] FAIL load_after_store_miss_count got %0d want 3", miss_count); end
   endtask

   task automatic test_mem_stall;
      int lat, mr, cw, rs, unstable0;
      logic [31:0] rd;
      unstable0 = memUnstable;
      stallTarget = 5;
      applyStimulus(1'b1, 32'h0000_0100, 32'hCAFE_F00D, lat, rd, mr, cw, rs);
      stallTarget = 0;
      checks++; if (lat !== 9) begin fails++; $display("[TB] FAIL stall_latency got %0d want 9", lat); end
      checks++; if (mr !== 6) begin fails++; $display("[TB] FAIL stall_mem_req_cycles got %0d want 6", mr); end
      checks++; if (memUnstable !== unstable0) begin fails++; $display("[TB] FAIL stall_request_stability got %0d changes want 0", memUnstable - unstable0); end
      checks++; if (memLastWriteData !== 32'hCAFE_F00D) begin fails++; $display("[TB] FAIL stall_mem_data got %h want cafef00d", memLastWriteData); end
      checks++; if (rs !== 1) begin fails++; $display("[TB] FAIL stall_resp_pulses got %0d want 1", rs); end
      checks++; if (miss_count !== 16'd4) begin fails++; $display("[TB] FAIL stall_miss_count got %0d want 4", miss_count); end
   endtask

   task automatic test_reset_mid;
      int rs0, cw0;
      holdResp = 1'b1;
      @(posedge clk); #1;
      rs0 = respCount; cw0 = cacheWriteCount;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_00C0; req_wdata = 32'h0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL mid_busy_req_ready got %0b want 0", req_ready); end
      checks++; if (mem_req_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_wait_mem_req_valid got %0b want 0", mem_req_valid); end
      checks++; if (miss_count !== 16'd5) begin fails++; $display("[TB] FAIL mid_miss_count got %0d want 5", miss_count); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      holdResp = 1'b0;
      forceResp = 1'b1;
      repeat (2) @(negedge clk);
      forceResp = 1'b0;
      checks++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL mid_reset_idle got %0b want 1", req_ready); end
      @(posedge clk); #1;
      checks++; if (respCount !== rs0) begin fails++; $display("[TB] FAIL mid_reset_resp_pulses got %0d want 0", respCount - rs0); end
      checks++; if (cacheWriteCount !== cw0) begin fails++; $display("[TB] FAIL mid_reset_cache_writes got %0d want 0", cacheWriteCount - cw0); end
      checks++; if (hit_count !== 16'd0) begin fails++; $display("[TB] FAIL mid_reset_hit_count got %0d want 0", hit_count); end
      checks++; if (miss_count !== 16'd0) begin fails++; $display("[TB] FAIL mid_reset_miss_count got %0d want 0", miss_count); end
   endtask

   task automatic test_hit_saturation;
      for (int n = 1; n <= 17; n++) begin
         @(negedge clk);
         s_req_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         s_req_valid = 1'b0;
         @(negedge clk);
         if (n == 1) begin
            checks++; if (s_resp_valid !== 1'b1) begin fails++; $display("[TB] FAIL sat_first_resp_valid got %0b want 1", s_resp_valid); end
            checks++; if (s_resp_rdata !== 32'h5555_AAAA) begin fails++; $display("[TB] FAIL sat_first_rdata got %h want 5555aaaa", s_resp_rdata); end
         end
         if (n == 14) begin
            checks++; if (s_hit_count !== 4'hE) begin fails++; $display("[TB] FAIL sat_count_14 got %h want e", s_hit_count); end
         end
         if (n == 15) begin
            checks++; if (s_hit_count !== 4'hF) begin fails++; $display("[TB] FAIL sat_count_15 got %h want f", s_hit_count); end
         end
         if (n == 17) begin
            checks++; if (s_hit_count !== 4'hF) begin fails++; $display("[TB] FAIL sat_count_17 got %h want f", s_hit_count); end
         end
         @(posedge clk);
      end
      checks++; if (s_miss_count !== 4'h0) begin fails++; $display("[TB] FAIL sat_miss_count got %h want 0", s_miss_count); end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      s_req_valid = 1'b0;
      test_reset();
      test_read_miss();
      test_read_hit();
      test_write_hit();
      test_write_miss();
      test_mem_stall();
      test_reset_mid();
      test_hit_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout after %0d checks", checks);
      $fatal(1, "[TB] watchdog");
   end

endmodule
